// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Ownership is granted round-robin and held for a whole message (up to the
// byte flagged by req_last) or until MAX_BURST bytes have gone out, whichever
// comes first. Each byte is handed to the transmitter with a one-cycle
// tx_start pulse, and the arbiter waits for tx_busy to fall before moving on.
//
// Ports
//   clk        : single clock, rising edge
//   reset_n    : synchronous, active-low reset
//   req_valid  : per-requester byte-available flag
//   req_data   : byte for requester i on bits [8i+7:8i]
//   req_last   : per-requester final-byte-of-message flag
//   req_ready  : per-requester byte-accepted strobe (combinational, SEND only)
//   tx_busy    : transmitter busy, from the cycle after tx_start to stop bit
//   tx_start   : one-cycle start pulse to the transmitter
//   tx_data    : byte to transmit, valid while tx_start is high, held otherwise
//   grant      : one-hot current owner, zero when idle
//   state      : FSM state for debug LEDs (IDLE=0, SEND=1, START=2, WAIT=3)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [1:0]             state
);

    localparam int OW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);
    localparam logic [7:0]         BURST_MAX = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [OW-1:0]        r_owner;
    logic [OW-1:0]        r_last_owner;
    logic [7:0]           r_cnt;
    logic                 r_last;
    logic                 r_tx_start;
    logic [7:0]           r_tx_data;

    logic [OW-1:0]        w_pick;
    logic [7:0]           w_owner_byte;
    logic [NUM_REQ-1:0]   w_req_ready;

    // Round-robin search starting one past the previous owner; the first
    // valid requester found (lowest offset) wins.
    function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [OW-1:0]      last);
        logic [OW-1:0] pick;
        logic [OW-1:0] idx;
        logic          found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx   = OW'((int'(last) + i) % NUM_REQ);
            pick  = (!found && valid[idx]) ? idx : pick;
            found = found | valid[idx];
        end
        return pick;
    endfunction

    assign w_pick       = rr_pick(req_valid, r_last_owner);
    assign w_owner_byte = req_data[{r_owner, 3'b000} +: 8];

    // Byte-accept strobe: only the owner, only in SEND, only when the
    // transmitter is free; forced low while reset is held.
    always_comb begin
        w_req_ready = '0;
        if (reset_n && (r_state == ST_SEND) && !tx_busy) begin
            w_req_ready = r_grant & req_valid;
        end else begin
            w_req_ready = '0;
        end
    end

    // Arbitration / transmit-handshake state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= OW'(NUM_REQ - 1);
            r_cnt        <= 8'd0;
            r_last       <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_owner <= w_pick;
                        r_grant <= ONE_HOT_0 << w_pick;
                        r_cnt   <= 8'd0;
                        r_state <= ST_SEND;
                    end else begin
                        r_grant <= '0;
                    end
                end
                ST_SEND: begin
                    // A dropped request releases the grant even if the
                    // transmitter is still busy.
                    if (!req_valid[r_owner]) begin
                        r_grant      <= '0;
                        r_last_owner <= r_owner;
                        r_cnt        <= 8'd0;
                        r_state      <= ST_IDLE;
                    end else if (!tx_busy) begin
                        r_tx_data  <= w_owner_byte;
                        r_last     <= req_last[r_owner];
                        r_cnt      <= r_cnt + 8'd1;
                        r_tx_start <= 1'b1;
                        r_state    <= ST_START;
                    end else begin
                        r_state <= ST_SEND;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!tx_busy) begin
                        if (r_last || (r_cnt == BURST_MAX)) begin
                            r_grant      <= '0;
                            r_last_owner <= r_owner;
                            r_cnt        <= 8'd0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_state <= ST_SEND;
                        end
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;
    assign grant     = r_grant;
    assign state     = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int MB = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [3:0]  grant;
    logic [1:0]  state;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .grant(grant), .state(state)
    );

    int checks = 0;
    int errors = 0;

    // per-requester message queues (fixed arrays with head/tail indices)
    logic [7:0] mem_d [4][64];
    logic       mem_l [4][64];
    int         head [4];
    int         tail [4];

    // expected transmit order from the reference model
    int exp_owner[$];
    int exp_byte[$];

    int         m_last;
    int         busy_left;
    logic [3:0] rdy_seen;
    logic       prev_start;
    logic       busy_prev;
    logic [7:0] last_txd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_q();
        for (int r = 0; r < 4; r++) begin
            head[r] = 0;
            tail[r] = 0;
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem_d[r][tail[r]] = d;
        mem_l[r][tail[r]] = l;
        tail[r]++;
    endtask

    function automatic bit all_empty();
        for (int r = 0; r < 4; r++) begin
            if (head[r] < tail[r]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: owners are served round-robin from one past the last
    // owner; each grant sends bytes until a last flag, MB bytes, or the
    // owner's queue runs dry, then the grant is released to that owner.
    function automatic void model_build();
        int h[4];
        int own;
        int cnt;
        bit done;
        bit any;
        for (int r = 0; r < 4; r++) h[r] = head[r];
        while (1) begin
            any = 1'b0;
            for (int r = 0; r < 4; r++) any = any | (h[r] < tail[r]);
            if (!any) break;
            own = -1;
            for (int i = 1; i <= 4; i++) begin
                int c;
                c = (m_last + i) % 4;
                if (own < 0 && h[c] < tail[c]) own = c;
            end
            cnt  = 0;
            done = 1'b0;
            while (!done) begin
                exp_owner.push_back(own);
                exp_byte.push_back(int'(mem_d[own][h[own]]));
                cnt++;
                done = mem_l[own][h[own]] || (cnt == MB);
                h[own]++;
                if (h[own] == tail[own]) done = 1'b1;
            end
            m_last = own;
        end
    endfunction

    task automatic drive_inputs();
        for (int r = 0; r < 4; r++) begin
            if (head[r] < tail[r]) begin
                req_valid[r]       = 1'b1;
                req_data[8*r +: 8] = mem_d[r][head[r]];
                req_last[r]        = mem_l[r][head[r]];
            end else begin
                req_valid[r]       = 1'b0;
                req_data[8*r +: 8] = 8'h00;
                req_last[r]        = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 4'h0;
        req_data  = 32'h0;
        req_last  = 4'h0;
        tx_busy   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 2'd0);
        chk("rst_grant", grant, 4'h0);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_ready", req_ready, 4'h0);
        reset_n    = 1'b1;
        tx_busy    = 1'b0;
        clear_q();
        m_last     = 3;
        busy_left  = 0;
        prev_start = 1'b0;
        busy_prev  = 1'b0;
        last_txd   = 8'h00;
        rdy_seen   = 4'h0;
    endtask

    // One clock of queue-driven traffic with a transmitter model attached.
    task automatic cycle();
        logic nb;
        @(posedge clk);
        for (int r = 0; r < 4; r++) begin
            if (rdy_seen[r]) head[r]++;
        end
        #1;
        chk("start_vs_state", tx_start, (state == 2'd2));
        chk("start_twice", prev_start & tx_start, 1'b0);
        nb = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        if (tx_start) begin
            chk("start_while_busy", busy_prev, 1'b0);
            chk("start_expected", (exp_owner.size() > 0), 1'b1);
            if (exp_owner.size() > 0) begin
                logic [3:0] eg;
                eg = 4'b0001 << exp_owner[0];
                chk("tx_grant", grant, eg);
                chk("tx_byte", tx_data, exp_byte[0]);
                last_txd = 8'(exp_byte[0]);
                void'(exp_owner.pop_front());
                void'(exp_byte.pop_front());
            end
            busy_left = $urandom_range(1, 8);
        end else begin
            chk("tx_data_hold", tx_data, last_txd);
        end
        prev_start = tx_start;
        tx_busy    = nb;
        busy_prev  = nb;
        drive_inputs();
        #1;
        rdy_seen = req_ready;
        chk("ready_rule", req_ready, ((state == 2'd1) && !tx_busy) ? (grant & req_valid) : 4'h0);
        chk("ready_onehot", ($countones(req_ready) <= 1), 1'b1);
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (!(all_empty() && exp_owner.size() == 0 && busy_left == 0 && state == 2'd0)
               && n < budget) begin
            cycle();
            n++;
        end
        chk("scenario_in_budget", (n < budget), 1'b1);
        chk("exp_drained", exp_owner.size(), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- basic arbitration: 0 and 2 valid, 0 first then 2 ----
        do_reset();
        push(0, 8'hA0, 1'b1);
        push(2, 8'hC0, 1'b1);
        model_build();
        drive_inputs();
        cycle();
        chk("first_grant", grant, 4'b0001);
        run_until_idle(200);

        // ---- requester 1: three-byte message ----
        clear_q();
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b1);
        model_build();
        drive_inputs();
        run_until_idle(300);

        // ---- requester 2 streams 20 bytes, requester 3 waiting ----
        clear_q();
        for (int i = 0; i < 20; i++) push(2, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 3; i++) push(3, 8'(8'h30 + i), (i == 2));
        model_build();
        drive_inputs();
        run_until_idle(2000);

        // ---- owner drops request in SEND (last owner is 2 -> 0 wins) ----
        tx_busy   = 1'b0;
        req_valid = 4'b0001;
        req_data  = 32'h0000_00EE;
        req_last  = 4'h0;
        tick();
        chk("drop_grant", grant, 4'b0001);
        chk("drop_state", state, 2'd1);
        req_valid = 4'h0;
        #1;
        chk("drop_ready", req_ready, 4'h0);
        tick();
        chk("drop_idle", state, 2'd0);
        chk("drop_grant0", grant, 4'h0);
        chk("drop_nostart", tx_start, 1'b0);
        tick();
        chk("drop_nostart2", tx_start, 1'b0);

        // ---- tx_busy held 100 cycles in SEND (last owner 0 -> 1 wins) ----
        req_valid = 4'b0010;
        req_data  = 32'h0000_5A00;
        req_last  = 4'b0010;
        tx_busy   = 1'b1;
        tick();
        chk("busy_grant", grant, 4'b0010);
        for (int i = 0; i < 100; i++) begin
            chk("busy_hold", {state, req_ready}, {2'd1, 4'h0});
            tick();
        end
        tx_busy = 1'b0;
        #1;
        chk("busy_release_ready", req_ready, 4'b0010);
        tick();
        chk("busy_start", {state, tx_start, tx_data}, {2'd2, 1'b1, 8'h5A});
        req_valid = 4'h0;
        tx_busy   = 1'b1;
        tick();
        chk("busy_wait", {state, tx_start}, {2'd3, 1'b0});
        tx_busy = 1'b0;
        tick();
        chk("busy_done", {state, grant}, {2'd0, 4'h0});

        // ---- reset during WAIT (last owner 1 -> 3 wins before reset) ----
        req_valid = 4'b1001;
        req_data  = 32'h7700_0011;
        req_last  = 4'h0;
        tick();
        chk("rw_grant", grant, 4'b1000);
        tick();
        chk("rw_start", {state, tx_start, tx_data}, {2'd2, 1'b1, 8'h77});
        tx_busy = 1'b1;
        tick();
        chk("rw_wait", state, 2'd3);
        reset_n = 1'b0;
        tick();
        chk("rw_reset", {state, grant, tx_start, tx_data, req_ready},
            {2'd0, 4'h0, 1'b0, 8'h00, 4'h0});
        reset_n = 1'b1;
        tx_busy = 1'b0;
        tick();
        chk("rw_prio0", grant, 4'b0001);
        chk("rw_nostart", tx_start, 1'b0);
        req_valid = 4'h0;
        tick();
        chk("rw_idle", state, 2'd0);

        // ---- randomized traffic against the reference model ----
        for (int round = 0; round < 4; round++) begin
            do_reset();
            for (int r = 0; r < 4; r++) begin
                int n;
                n = $urandom_range(0, 20);
                for (int k = 0; k < n; k++) begin
                    push(r, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
                end
            end
            model_build();
            drive_inputs();
            run_until_idle(4000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
